// File: rtl/floo_serial_link_flit_arbiter.sv
// ----------------------------------------------------------------------------
// floo_serial_link_flit_arbiter
//
// Merges the narrow-request (0), narrow-response (1) and wide (2) flit
// channels into one tagged flit stream for the serial-link data-link layer.
// Each channel is gated by a credit counter tracking free slots in the remote
// receive buffer, so a flit is only sent when the far end can store it.
// Channels are served round-robin; the winner is loaded into a single-entry
// output register whenever that register is empty or being drained.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   narrow_req_*             narrow request channel (valid/ready/data)
//   narrow_rsp_*             narrow response channel (valid/ready/data)
//   wide_*                   wide channel (valid/ready/data)
//   credit_i[2:0]            credit-return pulses, bit c = channel c
//   out_valid_o/out_ready_i  merged flit handshake
//   out_data_o               flit payload, zero-extended to OutWidth
//   out_chan_o               channel tag of out_data_o (0..2)
//   credit_cnt_o[c]          registered credit count of channel c
//   credit_err_o[c]          sticky credit-overflow flag of channel c
// ----------------------------------------------------------------------------

// Per-channel credit counter. Counts free remote slots; a returned credit
// that would push the count past NumCredits is dropped and flagged.
module floo_serial_link_credit_cnt #(
    parameter int unsigned NumCredits = 8,
    parameter int unsigned CntWidth   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                take_i,
    input  logic                credit_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                err_o
);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic                err_d, err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        // A flit and a credit in the same cycle cancel out.
        if (take_i && !credit_i) begin
            cnt_d = cnt_q - 1'b1;
        end else if (credit_i && !take_i) begin
            if (cnt_q < MaxCnt) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= MaxCnt;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;
endmodule

module floo_serial_link_flit_arbiter #(
    parameter int unsigned ReqWidth   = 64,
    parameter int unsigned RspWidth   = 64,
    parameter int unsigned WideWidth  = 576,
    parameter int unsigned NumCredits = 8,
    parameter int unsigned OutWidth   =
        (ReqWidth > RspWidth) ? ((ReqWidth > WideWidth) ? ReqWidth : WideWidth)
                              : ((RspWidth > WideWidth) ? RspWidth : WideWidth),
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         narrow_req_valid_i,
    output logic                         narrow_req_ready_o,
    input  logic [ReqWidth-1:0]          narrow_req_data_i,

    input  logic                         narrow_rsp_valid_i,
    output logic                         narrow_rsp_ready_o,
    input  logic [RspWidth-1:0]          narrow_rsp_data_i,

    input  logic                         wide_valid_i,
    output logic                         wide_ready_o,
    input  logic [WideWidth-1:0]         wide_data_i,

    input  logic [2:0]                   credit_i,

    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [OutWidth-1:0]          out_data_o,
    output logic [1:0]                   out_chan_o,

    output logic [2:0][CntWidth-1:0]     credit_cnt_o,
    output logic [2:0]                   credit_err_o
);
    localparam int unsigned NumChan = 3;

    // Successor in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] next_chan(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    logic [NumChan-1:0]               valid;
    logic [NumChan-1:0]               elig;
    logic [NumChan-1:0]               take;
    logic [NumChan-1:0][CntWidth-1:0] cnt;
    logic [NumChan-1:0]               err;

    logic [1:0]          ptr_d, ptr_q;
    logic [1:0]          cand;
    logic [1:0]          gnt_idx;
    logic                gnt_any;
    logic                load;
    logic [OutWidth-1:0] gnt_data;

    logic                out_valid_d, out_valid_q;
    logic [OutWidth-1:0] out_data_d, out_data_q;
    logic [1:0]          out_chan_d, out_chan_q;

    assign valid = {wide_valid_i, narrow_rsp_valid_i, narrow_req_valid_i};

    // Credit counters, one per channel.
    for (genvar c = 0; c < NumChan; c++) begin : g_cnt
        assign elig[c] = valid[c] && (cnt[c] != '0);

        floo_serial_link_credit_cnt #(
            .NumCredits (NumCredits),
            .CntWidth   (CntWidth)
        ) i_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .take_i   (take[c]),
            .credit_i (credit_i[c]),
            .cnt_o    (cnt[c]),
            .err_o    (err[c])
        );
    end

    // Round-robin search starting at ptr_q.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 0; k < NumChan; k++) begin
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
            cand = next_chan(cand);
        end
    end

    // Load when the output register is empty or draining this cycle. Gating
    // with rst_ni keeps every ready low while reset is asserted.
    assign load = rst_ni && gnt_any && (!out_valid_q || out_ready_i);

    always_comb begin
        take = '0;
        if (load) begin
            take[gnt_idx] = 1'b1;
        end
    end

    assign narrow_req_ready_o = take[0];
    assign narrow_rsp_ready_o = take[1];
    assign wide_ready_o       = take[2];

    always_comb begin
        unique case (gnt_idx)
            2'd0:    gnt_data = OutWidth'(narrow_req_data_i);
            2'd1:    gnt_data = OutWidth'(narrow_rsp_data_i);
            default: gnt_data = OutWidth'(wide_data_i);
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (load) begin
            ptr_d       = next_chan(gnt_idx);
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
        end else if (out_ready_i) begin
            // Payload and tag keep their last values once drained.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_chan_o   = out_chan_q;
    assign credit_cnt_o = cnt;
    assign credit_err_o = err;
endmodule

// File: doc/floo_serial_link_flit_arbiter.md
# floo_serial_link_flit_arbiter

Credit-gated, round-robin arbiter that merges the narrow-request, narrow-response and wide flit channels into a single tagged flit stream. It sits directly upstream of the serial-link data-link layer and feeds it one flit per cycle. Each channel is gated by a credit counter that tracks free receive-buffer slots on the remote side, so no flit is sent that the far end cannot store.

## Interface
- ReqWidth, 64: narrow request flit payload width in bits.
- RspWidth, 64: narrow response flit payload width in bits.
- WideWidth, 576: wide flit payload width in bits.
- NumCredits, 8: remote buffer depth per channel. Legal range 1..255.
- OutWidth, derived: max(ReqWidth, RspWidth, WideWidth).
- CntWidth, derived: $clog2(NumCredits+1).

- clk_i  in  1  serial-link clock. All logic is on the rising edge.
- rst_ni  in  1  reset. Synchronous, active-low.
- narrow_req_valid_i / narrow_req_ready_o / narrow_req_data_i  in/out/in  1/1/ReqWidth  narrow request channel.
- narrow_rsp_valid_i / narrow_rsp_ready_o / narrow_rsp_data_i  in/out/in  1/1/RspWidth  narrow response channel.
- wide_valid_i / wide_ready_o / wide_data_i  in/out/in  1/1/WideWidth  wide channel.
- credit_i  in  3  one-cycle credit-return pulses. Bit 0 = req, bit 1 = rsp, bit 2 = wide.
- out_valid_o  out  1  merged flit valid.
- out_ready_i  in  1  downstream (data-link layer) ready.
- out_data_o  out  OutWidth  flit payload, zero-extended.
- out_chan_o  out  2  channel tag: 0 = req, 1 = rsp, 2 = wide. Value 3 is never driven.
- credit_cnt_o  out  3×CntWidth  current credit count per channel.
- credit_err_o  out  3  sticky per-channel credit-overflow flag.

## Operation
- Eligibility: channel c is eligible when valid_c=1 and cnt_c>0.
- Arbitration:
  - Round-robin pointer ptr in {0,1,2}.
  - The grant goes to the first eligible channel searching ptr, ptr+1, ptr+2 (mod 3).
  - After an accepted input handshake on channel g, ptr becomes (g+1) mod 3. Otherwise ptr holds.
- Output register: a single entry, out_valid_o plus payload plus tag.
  - load = (grant exists) && (!out_valid_o || out_ready_i).
  - ready_c = load && grant==c. At most one ready is high per cycle.
  - A ready may depend combinationally on valid_c and out_ready_i. valid_c must never depend on ready_c.
  - On load: out_data_o = zero-extended data_g, out_chan_o = g, out_valid_o = 1.
  - On out handshake with no load: out_valid_o = 0. out_data_o and out_chan_o hold their last values.
- Credit counters, one per channel, width CntWidth:
  - Accepted flit on c, no credit_i[c]: cnt_c − 1.
  - credit_i[c], no accepted flit: cnt_c + 1, but only if cnt_c < NumCredits.
  - Both in the same cycle: cnt_c unchanged.
  - credit_i[c] with cnt_c == NumCredits and no accepted flit: count holds and credit_err_o[c] is set to 1. The flag stays set until reset.
  - Decrementing below 0 cannot occur, because cnt_c == 0 blocks eligibility.
- Reset values:
  - ptr = 0, cnt_c = NumCredits.
  - out_valid_o = 0, out_data_o = 0, out_chan_o = 0.
  - all ready outputs = 0, credit_err_o = 0.
- Reset mid-operation: a flit held in the output register is discarded. Counters return to NumCredits regardless of flits in flight; resetting the remote side together with this block is a system-level requirement.

## Timing
- Latency: an input handshake in cycle N gives out_valid_o=1 with that flit in cycle N+1.
- Throughput: one flit per cycle while out_ready_i=1 and some channel is eligible.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_chan_o stay constant and out_valid_o stays high.
- Credit visibility:
  - credit_cnt_o reflects the register value, i.e. updates from cycle N appear in cycle N+1.
  - A credit returned in cycle N makes a zero-credit channel eligible in cycle N+1, not in cycle N.
- Fairness: with all channels continuously eligible and out_ready_i=1, grants rotate 0,1,2,0,… Any eligible channel waits at most 2 accepted flits.

## Test plan
- Reset: rst_ni=0 for 2 cycles with all valids high → all readys 0, out_valid_o=0, credit_cnt_o = 8/8/8, credit_err_o=0. In the first cycle after reset release, req is granted.
- Round robin: all three valids held high, out_ready_i=1, credits returned every cycle → out_chan_o sequence 0,1,2,0,1,2. out_data_o carries each channel's data, zero-extended. No bubbles.
- Credit exhaustion: only wide valid, no credit_i, NumCredits=8 → exactly 8 flits pass and wide_ready_o then stays 0. One credit_i[2] pulse in cycle N → one more flit accepted in cycle N+1.
- Backpressure: out_ready_i=0 for 5 cycles after the first load → out_valid_o, out_data_o and out_chan_o constant, all input readys 0, counts unchanged. When out_ready_i returns to 1, a load and an out handshake occur in the same cycle.
- Credit edge cases:
  - credit_i[1] while cnt_rsp=8 → count stays 8 and credit_err_o[1]=1 until reset.
  - credit_i[0] in the same cycle as an accepted req flit → cnt_req unchanged.
- Mid-operation reset: assert rst_ni=0 while out_valid_o=1 and cnt_wide=3 → the next cycle shows out_valid_o=0 and cnt_wide=8.
